// File: rtl/bnn_seq_ctrl_if.sv
// Handshake and result bundle of the BNN sequencer: weight-load channel, start/done, activations.
// rd_addr/rd_data exist only when BNN_SEQ_READBACK_EN is defined.
interface bnn_seq_ctrl_if #(
  parameter int N_IN = 8,
  parameter int N_L2 = 4
);
  logic            wr_valid;
  logic [3:0]      wr_nibble;
  logic            wr_ready;
  logic            wr_clr;
  logic            start;
  logic [N_IN-1:0] in_vec;
  logic            busy;
  logic            done;
  logic [N_IN-1:0] l1_out;
  logic [N_L2-1:0] l2_out;
`ifdef BNN_SEQ_READBACK_EN
  logic [3:0]      rd_addr;
  logic [7:0]      rd_data;

  modport master (
    output wr_valid, wr_nibble, wr_clr, start, in_vec, rd_addr,
    input  wr_ready, busy, done, l1_out, l2_out, rd_data
  );
  modport slave (
    input  wr_valid, wr_nibble, wr_clr, start, in_vec, rd_addr,
    output wr_ready, busy, done, l1_out, l2_out, rd_data
  );
`else
  modport master (
    output wr_valid, wr_nibble, wr_clr, start, in_vec,
    input  wr_ready, busy, done, l1_out, l2_out
  );
  modport slave (
    input  wr_valid, wr_nibble, wr_clr, start, in_vec,
    output wr_ready, busy, done, l1_out, l2_out
  );
`endif
endinterface

// File: rtl/bnn_seq_ctrl.sv
// Sequencer for the 8-8-4 binary NN: one shared XNOR-popcount/threshold unit, one neuron per cycle.
// Optional combinational weight readback port with `define BNN_SEQ_READBACK_EN.
module bnn_seq_ctrl #(
  parameter int N_IN   = 8,
  parameter int N_L2   = 4,
  parameter int THRESH = 6
) (
  input  logic          clk,
  input  logic          reset,
  bnn_seq_ctrl_if.slave bus
);
  localparam int N_NEUR = N_IN + N_L2;
  localparam int MW     = $clog2(N_IN + 1);
  localparam int IW1    = $clog2(N_IN);
  localparam int IW2    = $clog2(N_L2);
  localparam logic [N_NEUR*N_IN-1:0] W_INIT = 96'h0F_F7_62_F9_3A_67_B7_ED_18_7A_41_A0;

  typedef enum logic [1:0] {S_IDLE, S_EVAL1, S_EVAL2, S_FIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [N_IN-1:0] r_weight [N_NEUR];
  logic [3:0]      r_ptr, r_temp, r_n, r_wn;
  logic            r_phase, r_wv;
  logic [N_IN-1:0] r_x, r_w, r_l1_work, r_l1_out;
  logic [N_L2-1:0] r_l2_work, r_l2_out;

  logic            w_start_acc, w_wr_acc, w_act;
  logic [N_IN-1:0] w_x, w_l1_nxt;
  logic [N_L2-1:0] w_l2_nxt;
  logic [MW-1:0]   w_match;

  assign w_start_acc = (r_state == S_IDLE) && bus.start;
  assign w_wr_acc    = bus.wr_valid && (r_state == S_IDLE) && !bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // EVAL2 drains one extra cycle: the evaluator runs one cycle behind the weight fetch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_EVAL1;
      S_EVAL1: if (r_n == 4'(N_IN - 1)) w_state_nxt = S_EVAL2;
      S_EVAL2: if (r_wv && r_wn == 4'(N_NEUR - 1)) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.wr_ready = (r_state == S_IDLE) && !bus.start;
    bus.busy     = (r_state != S_IDLE);
    bus.done     = (r_state == S_FIN);
    bus.l1_out   = r_l1_out;
    bus.l2_out   = r_l2_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEUR; i++) r_weight[i] <= W_INIT[i*N_IN +: N_IN];
      r_ptr   <= '0;
      r_phase <= 1'b0;
      r_temp  <= '0;
    end else if (bus.wr_clr) begin
      r_ptr   <= '0;
      r_phase <= 1'b0;
    end else if (w_wr_acc) begin
      if (!r_phase) begin
        r_temp  <= bus.wr_nibble;
        r_phase <= 1'b1;
      end else begin
        r_weight[r_ptr] <= {bus.wr_nibble, r_temp};
        r_phase         <= 1'b0;
        r_ptr           <= (r_ptr == 4'(N_NEUR - 1)) ? 4'd0 : r_ptr + 4'd1;
      end
    end
  end

  // Registered weight fetch; r_wn/r_wv tag the neuron the evaluator sees next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n  <= '0;
      r_wn <= '0;
      r_wv <= 1'b0;
      r_w  <= '0;
      r_x  <= '0;
    end else begin
      r_wv <= 1'b0;
      if (w_start_acc) begin
        r_x <= bus.in_vec;
        r_n <= '0;
      end else if ((r_state == S_EVAL1 || r_state == S_EVAL2) && r_n < 4'(N_NEUR)) begin
        r_w  <= r_weight[r_n];
        r_wn <= r_n;
        r_wv <= 1'b1;
        r_n  <= r_n + 4'd1;
      end
    end
  end

  always_comb begin
    w_x = r_x;
    if (r_wn >= 4'(N_IN))
      for (int j = 0; j < N_IN; j++) w_x[j] = r_l1_work[N_IN-1-j];
    w_match = '0;
    for (int j = 0; j < N_IN; j++)
      if (w_x[j] == r_w[j]) w_match = w_match + MW'(1);
    w_act    = (w_match >= MW'(THRESH));
    w_l1_nxt = r_l1_work;
    w_l2_nxt = r_l2_work;
    if (r_wv) begin
      if (r_wn < 4'(N_IN)) w_l1_nxt[IW1'(r_wn)] = w_act;
      else                 w_l2_nxt[IW2'(r_wn - 4'(N_IN))] = w_act;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l1_work <= '0;
      r_l2_work <= '0;
      r_l1_out  <= '0;
      r_l2_out  <= '0;
    end else begin
      r_l1_work <= w_l1_nxt;
      r_l2_work <= w_l2_nxt;
      if (r_state == S_EVAL2 && w_state_nxt == S_FIN) begin
        r_l1_out <= w_l1_nxt;
        r_l2_out <= w_l2_nxt;
      end
    end
  end

`ifdef BNN_SEQ_READBACK_EN
  always_comb bus.rd_data = (bus.rd_addr < 4'(N_NEUR)) ? r_weight[bus.rd_addr] : 8'h00;
`endif
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Randomized bench for bnn_seq_ctrl against a plain-arithmetic network and weight-loader model.
module tb_bnn_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bnn_seq_ctrl_if bif ();
  bnn_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bif));

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_w [12];
  int         m_ptr;
  bit         m_phase;
  logic [3:0] m_temp;
  logic [7:0] m_l1;
  logic [3:0] m_l2;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_w     = '{8'hA0, 8'h41, 8'h7A, 8'h18, 8'hED, 8'hB7, 8'h67, 8'h3A, 8'hF9, 8'h62, 8'hF7, 8'h0F};
    m_ptr   = 0;
    m_phase = 0;
    m_temp  = 4'h0;
    m_l1    = 8'h00;
    m_l2    = 4'h0;
  endfunction

  function automatic void model_accept(input logic [3:0] nib);
    if (!m_phase) begin
      m_temp  = nib;
      m_phase = 1;
    end else begin
      m_w[m_ptr] = {nib, m_temp};
      m_ptr      = (m_ptr + 1) % 12;
      m_phase    = 0;
    end
  endfunction

  // Neuron fires when at least 6 of 8 bits agree with its weight.
  function automatic logic [11:0] ref_infer(input logic [7:0] x);
    logic [7:0] l1, x2;
    logic [3:0] l2;
    for (int n = 0; n < 8; n++) l1[n] = (8 - $countones(x ^ m_w[n])) >= 6;
    for (int j = 0; j < 8; j++) x2[j] = l1[7-j];
    for (int k = 0; k < 4; k++) l2[k] = (8 - $countones(x2 ^ m_w[8+k])) >= 6;
    return {l2, l1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nibble(input logic [3:0] nib, input int max_gap);
    bit taken = 0;
    repeat ($urandom_range(0, max_gap)) tick();
    bif.wr_valid  = 1'b1;
    bif.wr_nibble = nib;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      taken = bif.wr_ready;
      tick();
    end
    bif.wr_valid = 1'b0;
    chk_eq("nibble_taken", 32'(taken), 32'd1);
    if (taken) model_accept(nib);
  endtask

  task automatic clr_pulse(input bit with_nib);
    bif.wr_clr = 1'b1;
    if (with_nib) begin
      bif.wr_valid  = 1'b1;
      bif.wr_nibble = 4'($urandom);
    end
    tick();
    bif.wr_clr   = 1'b0;
    bif.wr_valid = 1'b0;
    m_ptr   = 0;
    m_phase = 0;
  endtask

  // Start an inference; optionally re-assert start while busy or offer a nibble with start.
  task automatic run_infer(input logic [7:0] x, input int restart_at, input bit with_nib);
    logic [11:0] exp;
    int done_at = -1, n_done = 0, busy_bad = 0, hold_bad = 0;
    exp = ref_infer(x);
    bif.in_vec = x;
    bif.start  = 1'b1;
    if (with_nib) begin
      bif.wr_valid  = 1'b1;
      bif.wr_nibble = 4'($urandom);
    end
    @(negedge clk);
    chk_eq("rdy_low_on_start", 32'(bif.wr_ready), 32'd0);
    tick();
    bif.start    = 1'b0;
    bif.wr_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (bif.done) begin
        n_done++;
        done_at = k;
        chk_eq("l1_out", 32'(bif.l1_out), 32'(exp[7:0]));
        chk_eq("l2_out", 32'(bif.l2_out), 32'(exp[11:8]));
      end else if (k < 13) begin
        if (bif.l1_out !== m_l1 || bif.l2_out !== m_l2) hold_bad++;
      end
      if ((k <= 13) != (bif.busy === 1'b1)) busy_bad++;
      if (k == restart_at) begin
        bif.start  = 1'b1;
        bif.in_vec = ~x;
      end else if (k == restart_at + 1) begin
        bif.start = 1'b0;
      end
      tick();
    end
    bif.start = 1'b0;
    chk_eq("done_latency", 32'(done_at), 32'd13);
    chk_eq("done_count", 32'(n_done), 32'd1);
    chk_eq("busy_window_errs", 32'(busy_bad), 32'd0);
    chk_eq("hold_while_busy_errs", 32'(hold_bad), 32'd0);
    m_l1 = exp[7:0];
    m_l2 = exp[11:8];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bif.wr_valid  = 1'b0;
    bif.wr_nibble = 4'h0;
    bif.wr_clr    = 1'b0;
    bif.start     = 1'b0;
    bif.in_vec    = 8'h00;
`ifdef BNN_SEQ_READBACK_EN
    bif.rd_addr   = 4'h0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy", 32'(bif.busy), 32'd0);
    chk_eq("rst_done", 32'(bif.done), 32'd0);
    chk_eq("rst_l1", 32'(bif.l1_out), 32'd0);
    chk_eq("rst_l2", 32'(bif.l2_out), 32'd0);
    reset = 1'b0;
    tick();
    chk_eq("idle_rdy", 32'(bif.wr_ready), 32'd1);

    run_infer(8'hFF, -1, 0);
    chk_eq("ff_l1_const", 32'(bif.l1_out), 32'h30);
    chk_eq("ff_l2_const", 32'(bif.l2_out), 32'h8);
    run_infer(8'h00, -1, 0);
    chk_eq("00_l1_const", 32'(bif.l1_out), 32'h0B);
    chk_eq("00_l2_const", 32'(bif.l2_out), 32'h0);

    repeat (24) send_nibble(4'h0, 3);
    run_infer(8'h00, -1, 0);
    chk_eq("zero_w_l1", 32'(bif.l1_out), 32'hFF);
    chk_eq("zero_w_l2", 32'(bif.l2_out), 32'h0);
    send_nibble(4'hF, 1);
    send_nibble(4'hF, 1);
    run_infer(8'h00, -1, 0);
    chk_eq("wrap_l1", 32'(bif.l1_out), 32'hFE);

    send_nibble(4'h5, 0);
    clr_pulse(0);
    send_nibble(4'h0, 0);
    send_nibble(4'h0, 0);
    run_infer(8'h00, -1, 0);
    chk_eq("clr_l1", 32'(bif.l1_out), 32'hFF);

    send_nibble(4'h3, 0);
    clr_pulse(1);
    send_nibble(4'h9, 0);
    run_infer(8'h5A, -1, 1);
    send_nibble(4'hC, 0);
    run_infer(8'hA5, -1, 0);
    run_infer(8'h3C, 5, 0);

    bif.in_vec = 8'h81;
    bif.start  = 1'b1;
    tick();
    bif.start = 1'b0;
    repeat (5) tick();
    chk_eq("pre_rst_busy", 32'(bif.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_eq("midrst_busy", 32'(bif.busy), 32'd0);
    chk_eq("midrst_done", 32'(bif.done), 32'd0);
    chk_eq("midrst_l1", 32'(bif.l1_out), 32'd0);
    chk_eq("midrst_l2", 32'(bif.l2_out), 32'd0);
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk_eq("post_rst_rdy", 32'(bif.wr_ready), 32'd1);

`ifdef BNN_SEQ_READBACK_EN
    bif.rd_addr = 4'd4;
    #1 chk_eq("rd_4", 32'(bif.rd_data), 32'hED);
    bif.rd_addr = 4'd13;
    #1 chk_eq("rd_13", 32'(bif.rd_data), 32'h00);
    for (int a = 0; a < 12; a++) begin
      bif.rd_addr = 4'(a);
      #1 chk_eq("rd_all", 32'(bif.rd_data), 32'(m_w[a]));
    end
    tick();
`endif

    for (int it = 0; it < 25; it++) begin
      int nn;
      nn = $urandom_range(0, 6);
      for (int i = 0; i < nn; i++) send_nibble(4'($urandom), 2);
      if ($urandom_range(0, 5) == 0) clr_pulse(1'($urandom_range(0, 1)));
      run_infer(8'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1,
                1'($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bnn_seq_ctrl.md
Name: bnn_seq_ctrl

Overview:
- Time-multiplexed sequencer for the 8-8-4 binary neural network.
- Holds the 12 neuron weight bytes and a nibble-serial weight-load channel with valid/ready handshake.
- Drives a single shared XNOR-popcount/threshold unit across all 12 neurons, one neuron per cycle, under a start/done handshake.
- Replaces 12 parallel popcount trees with one unit plus a control FSM.

Parameters:
- N_IN, 8, input vector width and layer-1 neuron count.
- N_L2, 4, layer-2 neuron count.
- THRESH, 6, activation threshold: neuron fires when match count >= THRESH.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- wr_valid  input  1  weight nibble offered
- wr_nibble  input  4  weight nibble data
- wr_ready  output  1  nibble accepted when wr_valid & wr_ready
- wr_clr  input  1  synchronous: load pointer := 0, nibble phase := low
- start  input  1  request one inference
- in_vec  input  8  network input, sampled on accepted start
- busy  output  1  inference in progress
- done  output  1  one-cycle pulse, results valid
- l1_out  output  8  layer-1 activations, bit n = neuron n
- l2_out  output  4  layer-2 activations, bit k = neuron 8+k

Behaviour:
- Reset:
  - Weights load defaults, neuron 0..11: A0 41 7A 18 ED B7 67 3A F9 62 F7 0F (hex).
  - Load pointer 0, nibble phase low, state IDLE.
  - busy 0, done 0, l1_out 0, l2_out 0.
  - Reset mid-inference aborts; outputs return to 0.
- States:
  - IDLE -> EVAL1 on start accepted.
  - EVAL1 (n = 0..7) -> EVAL2 after n = 7.
  - EVAL2 (n = 8..11) -> FIN after n = 11.
  - FIN -> IDLE unconditionally.
- Weight load:
  - wr_ready = (state == IDLE) & ~start.
  - First accepted nibble -> temp[3:0]. Second accepted nibble -> weight[ptr] = {nibble, temp}; ptr increments.
  - ptr wraps 11 -> 0.
  - wr_clr has priority over a same-cycle accepted nibble; that nibble is dropped.
- Start:
  - Accepted only in IDLE. start outside IDLE is ignored; there is no queueing.
  - start beats wr_valid in the same cycle.
  - A half-loaded word (phase high) is retained across the inference.
- Evaluation, one neuron per cycle:
  - match = popcount(~(x ^ w[n])), 4-bit, range 0..8; act = (match >= THRESH).
  - EVAL1: x = in_vec captured at the start edge.
  - EVAL2: x[j] = l1_work[7-j] (bit-reversed layer-1 result).
  - Results accumulate in working registers. l1_out/l2_out update only on entering FIN, so they hold the previous results while busy.
- Timing:
  - start accepted at edge T: busy = 1 from edge T through edge T+13 (cleared entering IDLE).
  - Layer-1 neuron n is evaluated in the cycle after edge T+1+n.
  - done = 1 only in FIN, i.e. the cycle after edge T+13. l1_out/l2_out are valid in that cycle.
  - Earliest next start is accepted in the FIN cycle? No: only in IDLE, so the earliest next start is at edge T+14.
- Weight writes cannot occur during EVAL (wr_ready = 0), so weights are stable across an inference.

Optional Feature:
- Macro: BNN_SEQ_READBACK_EN
- With the macro: adds input rd_addr[3:0] and output rd_data[7:0] = weight[rd_addr], combinational. rd_addr 12..15 returns 00.
- Without the macro: neither port exists and the weight array has no read path besides the evaluator.

Test Plan:
- Reset, then start with in_vec=FF -> done pulses exactly 13 cycles after the start edge; l1_out=30, l2_out=8.
- Reset, then start with in_vec=00 -> l1_out=0B, l2_out=0.
- Load 24 nibbles of 0 with random wr_valid gaps, then start with in_vec=00 -> l1_out=FF, l2_out=0. Then load 2 more nibbles F,F -> weight[0]=FF (wrap). Start with in_vec=00 -> l1_out=FE.
- Send one nibble, assert wr_clr, send nibbles 0,0 -> weight[0]=00 (not temp-merged). Also: start and wr_valid in the same cycle -> wr_ready=0, nibble not taken, inference runs.
- Assert start while busy -> ignored: exactly one done, and l1_out unchanged until FIN. Assert reset at cycle 5 of EVAL1 -> busy, done, l1_out, l2_out all 0 immediately.
- Readback (BNN_SEQ_READBACK_EN): after reset, rd_addr=4 -> ED, rd_addr=13 -> 00.
